pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for the RV32 core.
//  - Holds the architectural PC and fetches from instruction memory over a valid/ready request/response bus.
//  - Presents the fetched word to decode through a valid/ready handshake.
//  - When decode accepts an instruction, loads next_pc from the next-PC select mux, so it sits directly

---
 rtl/pc_fetch_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter register and instruction-fetch sequencer for the RV32 core.
// Holds the architectural PC, issues one fetch at a time over a valid/ready
// request/response bus, and presents the fetched word to decode through a
// valid/ready handshake. When decode consumes an instruction, the PC is
// loaded from next_pc, which comes from the next-PC select mux. That mux sits
// directly upstream of this block and is fed back with pc and pc_plus_4.
//
// Sequence per instruction: S_REQ -> S_WAIT -> S_HOLD -> S_REQ.
// With a zero-wait memory this takes at least three cycles.
// A bus error or a misaligned next_pc parks the unit in S_FAULT until reset.
//
// Parameters
//   RESET_PC        PC loaded on reset. It must be word aligned.
//
// Ports
//   clk             in   1   core clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   next_pc         in   32  PC of the instruction after the one being consumed
//   pc              out  32  current architectural PC
//   pc_plus_4       out  32  pc + 4, modulo 2^32
//   imem_req_valid  out  1   fetch request valid
//   imem_req_ready  in   1   memory accepts request
//   imem_req_addr   out  32  fetch address (always equal to pc)
//   imem_rsp_valid  in   1   response data valid
//   imem_rsp_data   in   32  fetched instruction word
//   imem_rsp_err    in   1   bus error on this response
//   instr_valid     out  1   instr holds a valid fetched word
//   instr           out  32  instruction to decode
//   instr_ready     in   1   decode consumes instr this cycle
//   fetch_fault     out  1   sticky: misaligned next_pc or bus error
//   fault_pc        out  32  PC of the faulting fetch, or the misaligned target
//   fetch_count     out  32  instructions consumed, wraps at 2^32
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        instr_ready,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    // A misaligned reset vector would fetch from a bad address on the very
    // first request, so it is rejected at elaboration.
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
        $error("pc_fetch_unit: RESET_PC must be word aligned");
    end

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Architectural and datapath state
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    // Registered handshake / status outputs.
    // These are computed from the next state. Each one therefore changes on
    // the same edge as the state, and no combinational path runs from an
    // input to these outputs.
    logic        req_valid_q, req_valid_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_fault_q, fetch_fault_d;

    // Handshake events for the current cycle
    logic        req_accept;
    logic        rsp_ok;
    logic        rsp_bad;
    logic        consume;
    logic        next_pc_aligned;

    // A request counts as accepted only while we are actually driving valid.
    // This covers the first cycle after reset: the state is already S_REQ,
    // but imem_req_valid is still low.
    assign req_accept      = (state_q == S_REQ) && req_valid_q && imem_req_ready;
    assign rsp_ok          = (state_q == S_WAIT) && imem_rsp_valid && !imem_rsp_err;
    assign rsp_bad         = (state_q == S_WAIT) && imem_rsp_valid && imem_rsp_err;
    assign consume         = (state_q == S_HOLD) && instr_ready;
    assign next_pc_aligned = (next_pc[1:0] == 2'b00);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (req_accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_bad) begin
                    state_d = S_FAULT;
                end else if (rsp_ok) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (consume) begin
                    state_d = next_pc_aligned ? S_REQ : S_FAULT;
                end
            end
            S_FAULT: begin
                // Terminal until reset.
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // The outputs are decoded from the upcoming state and then registered.
    // -----------------------------------------------------------------------
    always_comb begin
        req_valid_d   = (state_d == S_REQ);
        instr_valid_d = (state_d == S_HOLD);
        fetch_fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        fault_pc_d    = fault_pc_q;
        fetch_count_d = fetch_count_q;

        // The instruction register is written only by a good response.
        // It then stays unchanged for the whole S_HOLD stall.
        if (rsp_ok) begin
            instr_d = imem_rsp_data;
        end

        // A bus error records the address of the failed fetch.
        if (rsp_bad) begin
            fault_pc_d = pc_q;
        end

        // This is the only cycle in which pc moves and next_pc is looked at.
        // A misaligned target is still taken as the architectural PC, so the
        // instruction that was consumed is counted, and the target is also
        // recorded as the fault address.
        if (consume) begin
            pc_d          = next_pc;
            fetch_count_d = fetch_count_q + 32'd1;
            if (!next_pc_aligned) begin
                fault_pc_d = next_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            fault_pc_q    <= 32'h0000_0000;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign pc             = pc_q;
    assign pc_plus_4      = pc_q + 32'd4;
    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign fetch_fault    = fetch_fault_q;
    assign fault_pc       = fault_pc_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed testbench for pc_fetch_unit. Inputs are driven on the falling
// edge, and outputs are compared against hand-computed values one time unit
// later.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .next_pc        (next_pc),
        .pc             (pc),
        .pc_plus_4      (pc_plus_4),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_ready    (instr_ready),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        next_pc        = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        instr_ready    = 1'b0;

        // ---------------- reset values ----------------
        step();
        step();
        chk("rst_pc",          pc,             32'h0);
        chk("rst_pc_plus_4",   pc_plus_4,      32'h4);
        chk("rst_req_valid",   imem_req_valid, 32'h0);
        chk("rst_instr_valid", instr_valid,    32'h0);
        chk("rst_instr",       instr,          32'h0);
        chk("rst_fault",       fetch_fault,    32'h0);
        chk("rst_fault_pc",    fault_pc,       32'h0);
        chk("rst_count",       fetch_count,    32'h0);

        rst_n = 1'b1;
        step();
        chk("first_req_valid", imem_req_valid, 32'h1);
        chk("first_req_addr",  imem_req_addr,  32'h0);

        // ---------------- 1: zero-wait stream 0,4,8 ----------------
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t1_req_valid%0d", k), imem_req_valid, 32'h1);
            chk($sformatf("t1_addr%0d", k),      imem_req_addr,  32'(4 * k));
            chk($sformatf("t1_iv_req%0d", k),    instr_valid,    32'h0);
            imem_req_ready = 1'b1;
            step();
            chk($sformatf("t1_wait_valid%0d", k), imem_req_valid, 32'h0);
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'h0000_0013;
            step();
            chk($sformatf("t1_iv_hold%0d", k), instr_valid, 32'h1);
            chk($sformatf("t1_instr%0d", k),   instr,       32'h0000_0013);
            imem_rsp_valid = 1'b0;
            instr_ready    = 1'b1;
            next_pc        = 32'(4 * k + 4);
            step();
            instr_ready    = 1'b0;
        end
        chk("t1_count",    fetch_count,   32'd3);
        chk("t1_pc",       pc,            32'hC);
        chk("t1_pc_plus4", pc_plus_4,     32'h10);

        // ---------------- 2: request stalled 5 cycles ----------------
        // A stray response and a stray instr_ready arrive outside their
        // states and must not change anything.
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        instr_ready    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t2_valid%0d", k), imem_req_valid, 32'h1);
            chk($sformatf("t2_addr%0d", k),  imem_req_addr,  32'hC);
            chk($sformatf("t2_count%0d", k), fetch_count,    32'd3);
            chk($sformatf("t2_fault%0d", k), fetch_fault,    32'h0);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        step();
        chk("t2_wait_valid", imem_req_valid, 32'h0);
        chk("t2_wait_iv",    instr_valid,    32'h0);
        imem_req_ready = 1'b0;

        // ---------------- 3: decode stall in S_HOLD ----------------
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        // The response bus keeps wiggling during the stall and is ignored.
        imem_rsp_data  = 32'hBAD0_0000;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t3_instr%0d", k), instr,          32'hDEAD_BEEF);
            chk($sformatf("t3_iv%0d", k),    instr_valid,    32'h1);
            chk($sformatf("t3_pc%0d", k),    pc,             32'hC);
            chk($sformatf("t3_req%0d", k),   imem_req_valid, 32'h0);
        end
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b1;
        next_pc        = 32'h100;
        step();
        instr_ready    = 1'b0;
        chk("t3_req_valid", imem_req_valid, 32'h1);
        chk("t3_addr",      imem_req_addr,  32'h100);
        chk("t3_count",     fetch_count,    32'd4);
        chk("t3_iv_after",  instr_valid,    32'h0);

        // ---------------- 4: misaligned next_pc ----------------
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b1;
        next_pc        = 32'h0000_0102;
        step();
        chk("t4_fault",    fetch_fault,    32'h1);
        chk("t4_fault_pc", fault_pc,       32'h102);
        chk("t4_pc",       pc,             32'h102);
        chk("t4_count",    fetch_count,    32'd5);
        chk("t4_iv",       instr_valid,    32'h0);
        chk("t4_req",      imem_req_valid, 32'h0);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t4_req_after%0d", k),   imem_req_valid, 32'h1 - 32'h1);
            chk($sformatf("t4_fault_after%0d", k), fetch_fault,    32'h1);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b0;

        // ---------------- reset out of S_FAULT ----------------
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_fault", fetch_fault, 32'h0);
        chk("rst_async_pc",    pc,          32'h0);
        chk("rst_async_count", fetch_count, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst2_req_valid", imem_req_valid, 32'h1);

        // ---------------- 5: bus error at pc 0x40 ----------------
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b1;
        next_pc        = 32'h40;
        step();
        instr_ready    = 1'b0;
        chk("t5_addr", imem_req_addr, 32'h40);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        chk("t5_fault",    fetch_fault,    32'h1);
        chk("t5_fault_pc", fault_pc,       32'h40);
        chk("t5_iv",       instr_valid,    32'h0);
        chk("t5_req",      imem_req_valid, 32'h0);
        chk("t5_count",    fetch_count,    32'd1);

        // ---------------- 6: reset during S_WAIT, late response ----------------
        @(negedge clk);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("t6_in_wait", imem_req_valid, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_iv",  instr_valid,    32'h0);
        chk("t6_rst_req", imem_req_valid, 32'h0);
        step();
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0055;
        step();
        chk("t6_late_req",   imem_req_valid, 32'h1);
        chk("t6_late_addr",  imem_req_addr,  32'h0);
        chk("t6_late_iv",    instr_valid,    32'h0);
        step();
        imem_rsp_valid = 1'b0;
        chk("t6_late_req2",  imem_req_valid, 32'h1);
        chk("t6_late_iv2",   instr_valid,    32'h0);
        chk("t6_late_fault", fetch_fault,    32'h0);
        chk("t6_late_instr", instr,          32'h0);
        chk("t6_count0",     fetch_count,    32'h0);

        // Preset the counter one below the wrap point, then consume once.
        @(negedge clk);
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_q;
        #1;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        chk("t6_pre_wrap", fetch_count, 32'hFFFF_FFFF);
        instr_ready    = 1'b1;
        next_pc        = 32'h4;
        step();
        instr_ready    = 1'b0;
        chk("t6_wrap",     fetch_count, 32'h0);
        chk("t6_wrap_pc",  pc,          32'h4);
        chk("t6_wrap_flt", fetch_fault, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
